set_time12_24: RTL and testbench

SET_TIME12_24 -- requirements
Module: set_time12_24

---
 rtl/set_time12_24_pkg.sv | 56 +++++
 rtl/set_time12_24_h12_to_h24.sv | 22 ++
 rtl/set_time12_24.sv | 144 ++++++++++++++
 tb/tb_set_time12_24.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/set_time12_24_pkg.sv
// Shared definitions for the time-set editor: FSM states, field codes,
// bit ranges of the 20-bit BCD time word, field limits and small BCD helpers.
// Ports: none (package).
package set_time12_24_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOUR,
    ST_MIN,
    ST_SEC,
    ST_AMPM,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  // Time word layout: {hour[19:14], min[13:7], sec[6:0]}, all BCD
  localparam int HOUR_MSB = 19;
  localparam int HOUR_LSB = 14;
  localparam int MIN_MSB  = 13;
  localparam int MIN_LSB  = 7;
  localparam int SEC_MSB  = 6;
  localparam int SEC_LSB  = 0;

  localparam logic [6:0] HOUR24_MAX = 7'd23;
  localparam logic [6:0] HOUR12_MAX = 7'd12;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  // {3b tens, 4b units} BCD -> binary (0..79)
  function automatic logic [6:0] bcd_to_bin(input logic [6:0] b);
    return {1'b0, b[6:4], 3'b000} + {3'b000, b[6:4], 1'b0} + {3'b000, b[3:0]};
  endfunction

  // binary (0..79) -> {3b tens, 4b units} BCD
  function automatic logic [6:0] bin_to_bcd(input logic [6:0] v);
    return {3'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // +/-1 with wrap between 0 and max_bin, operating on a BCD value
  function automatic logic [6:0] bcd_step(input logic [6:0] b, input logic up,
                                          input logic [6:0] max_bin);
    logic [6:0] v;
    logic [6:0] n;
    v = bcd_to_bin(b);
    if (up) begin
      n = (v >= max_bin) ? 7'd0 : v + 7'd1;
    end else begin
      n = ((v == 7'd0) || (v > max_bin)) ? max_bin : v - 7'd1;
    end
    return bin_to_bcd(n);
  endfunction

endpackage

// File: rtl/set_time12_24_h12_to_h24.sv
// Combinational 12h (hour12 00..12 + pm) to 24h BCD hour conversion.
// Ports: hour12 [5:0] BCD in, pm in, hour24 [5:0] BCD out.
// pm with 01..11 adds twelve; 00 and 12 pass through unchanged.
module h12_to_h24
  import set_time12_24_pkg::*;
(
  input  logic [5:0] hour12,
  input  logic       pm,
  output logic [5:0] hour24
);

  logic [6:0] h_bin;

  always_comb begin
    h_bin  = bcd_to_bin({1'b0, hour12});
    hour24 = hour12;
    if (pm && (h_bin >= 7'd1) && (h_bin <= 7'd11)) begin
      hour24 = 6'(bin_to_bcd(h_bin + 7'd12));
    end
  end

endmodule

// File: rtl/set_time12_24.sv
// Button-driven time editor: captures cur_time, steps hour/min/sec (and AM/PM
// in 12h mode) in BCD, then strobes load with the 24h result in COMMIT.
// Ports: clk, reset (sync, active-high), mod12_24, cur_time[19:0],
//   btn_next/up/down/cancel pulses; edit_time[19:0], edit_pm, field[1:0],
//   editing, load, load_time[19:0].
module set_time12_24
  import set_time12_24_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mod12_24,
  input  logic [19:0] cur_time,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_cancel,
  output logic [19:0] edit_time,
  output logic        edit_pm,
  output logic [1:0]  field,
  output logic        editing,
  output logic        load,
  output logic [19:0] load_time
);

  state_t      state_q, state_d;
  // hour_q holds hour12 in 12h mode, hour24 in 24h mode
  logic [5:0]  hour_q, hour_d;
  logic [6:0]  min_q, min_d;
  logic [6:0]  sec_q, sec_d;
  logic        pm_q, pm_d;
  // mode latched at capture; a later mismatch aborts the edit
  logic        mode_q, mode_d;
  logic [19:0] load_time_q, load_time_d;

  logic [5:0]  hour24;
  logic [6:0]  cur_hour_bin;
  logic [6:0]  hour_max;
  logic        step_up, step_dn;
  logic        hour_0_or_12;

  h12_to_h24 u_h12_to_h24 (
    .hour12 (hour_q),
    .pm     (pm_q),
    .hour24 (hour24)
  );

  assign edit_time = {hour24, min_q, sec_q};
  assign edit_pm   = pm_q;
  assign load_time = load_time_q;

  always_comb begin
    state_d      = state_q;
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    pm_d         = pm_q;
    mode_d       = mode_q;
    load_time_d  = load_time_q;

    // up+down together cancels out
    step_up      = btn_up & ~btn_down;
    step_dn      = btn_down & ~btn_up;
    hour_max     = mode_q ? HOUR12_MAX : HOUR24_MAX;
    hour_0_or_12 = (hour_q == 6'h00) || (hour_q == 6'h12);
    cur_hour_bin = bcd_to_bin({1'b0, cur_time[HOUR_MSB:HOUR_LSB]});

    case (state_q)
      ST_IDLE: begin
        if (btn_next) begin
          state_d = ST_HOUR;
          mode_d  = mod12_24;
          min_d   = cur_time[MIN_MSB:MIN_LSB];
          sec_d   = cur_time[SEC_MSB:SEC_LSB];
          if (mod12_24 && (cur_hour_bin >= 7'd13)) begin
            hour_d = 6'(bin_to_bcd(cur_hour_bin - 7'd12));
            pm_d   = 1'b1;
          end else begin
            hour_d = cur_time[HOUR_MSB:HOUR_LSB];
            pm_d   = 1'b0;
          end
        end
      end

      ST_COMMIT: state_d = ST_IDLE;

      default: begin
        if (btn_cancel || (mod12_24 != mode_q)) begin
          state_d = ST_IDLE;
        end else if (btn_next) begin
          case (state_q)
            ST_HOUR: begin
              state_d = ST_MIN;
              if (hour_0_or_12) pm_d = 1'b0;
            end
            ST_MIN:  state_d = ST_SEC;
            ST_SEC:  state_d = mode_q ? ST_AMPM : ST_COMMIT;
            default: state_d = ST_COMMIT;
          endcase
          // Capture on entry so load_time is already valid during COMMIT
          if (state_d == ST_COMMIT) load_time_d = edit_time;
        end else if (step_up || step_dn) begin
          case (state_q)
            ST_HOUR: hour_d = 6'(bcd_step({1'b0, hour_q}, step_up, hour_max));
            ST_MIN:  min_d  = bcd_step(min_q, step_up, MINSEC_MAX);
            ST_SEC:  sec_d  = bcd_step(sec_q, step_up, MINSEC_MAX);
            default: pm_d   = hour_0_or_12 ? 1'b0 : ~pm_q;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    editing = (state_q != ST_IDLE);
    load    = (state_q == ST_COMMIT);
    case (state_q)
      ST_HOUR:          field = FIELD_HOUR;
      ST_MIN:           field = FIELD_MIN;
      ST_SEC, ST_AMPM:  field = FIELD_SEC;
      default:          field = FIELD_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      pm_q        <= 1'b0;
      mode_q      <= 1'b0;
      load_time_q <= '0;
    end else begin
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      pm_q        <= pm_d;
      mode_q      <= mode_d;
      load_time_q <= load_time_d;
    end
  end

endmodule

// File: tb/tb_set_time12_24.sv
// Bench for set_time12_24: table of directed cycles, hand-written wrap/abort
// sequences, then random stimulus against an integer-arithmetic model.
module tb_set_time12_24;

  logic        clk = 1'b0;
  logic        reset, mod12_24, btn_next, btn_up, btn_down, btn_cancel;
  logic [19:0] cur_time;
  logic [19:0] edit_time, load_time;
  logic        edit_pm, editing, load;
  logic [1:0]  field;

  always #5 clk = ~clk;

  set_time12_24 dut (
    .clk(clk), .reset(reset), .mod12_24(mod12_24), .cur_time(cur_time),
    .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
    .btn_cancel(btn_cancel), .edit_time(edit_time), .edit_pm(edit_pm),
    .field(field), .editing(editing), .load(load), .load_time(load_time)
  );

  int checks = 0;
  int failures = 0;
  int load_cnt = 0;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  function automatic logic [19:0] mk(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] f, input logic ed,
                         input logic ld, input logic [19:0] t, input logic pm,
                         input logic [19:0] lt);
    chk({tag, ".field"}, {18'd0, field}, {18'd0, f});
    chk({tag, ".editing"}, {19'd0, editing}, {19'd0, ed});
    chk({tag, ".load"}, {19'd0, load}, {19'd0, ld});
    chk({tag, ".edit_time"}, edit_time, t);
    chk({tag, ".edit_pm"}, {19'd0, edit_pm}, {19'd0, pm});
    chk({tag, ".load_time"}, load_time, lt);
  endtask

  // Apply inputs, clock once, leave #1 after the edge for sampling
  task automatic drive(input logic r, input logic m, input logic [19:0] c,
                       input logic n, input logic u, input logic d, input logic k);
    reset = r; mod12_24 = m; cur_time = c;
    btn_next = n; btn_up = u; btn_down = d; btn_cancel = k;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, mod;
    logic [19:0] cur;
    logic        nxt, up, dn, cn;
    logic [1:0]  f;
    logic        ed, ld;
    logic [19:0] t;
    logic        pm;
    logic [19:0] lt;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic mod, input logic [19:0] cur,
                               input logic [3:0] btn, input logic [1:0] f, input logic ed,
                               input logic ld, input logic [19:0] t, input logic pm,
                               input logic [19:0] lt);
    vec_t v;
    v.rst = rst; v.mod = mod; v.cur = cur;
    v.nxt = btn[3]; v.up = btn[2]; v.dn = btn[1]; v.cn = btn[0];
    v.f = f; v.ed = ed; v.ld = ld; v.t = t; v.pm = pm; v.lt = lt;
    return v;
  endfunction

  // ---------------- behavioural model (plain integers) ----------------
  int m_pos;   // 0 idle, 1 hour, 2 min, 3 sec, 4 ampm, 5 commit
  int m_h, m_m, m_s, m_pm, m_mcap;
  int m_lh, m_lm, m_ls;

  function automatic int conv(input int h, input int pm);
    return (pm != 0 && h >= 1 && h <= 11) ? h + 12 : h;
  endfunction

  function automatic int wrap(input int v, input int up, input int max);
    return up != 0 ? (v + 1) % (max + 1) : (v + max) % (max + 1);
  endfunction

  task automatic model_step(input int r, input int md, input int ch, input int cm,
                            input int cs, input int n, input int u, input int d, input int k);
    if (r != 0) begin
      m_pos = 0; m_h = 0; m_m = 0; m_s = 0; m_pm = 0; m_mcap = 0;
      m_lh = 0; m_lm = 0; m_ls = 0;
    end else if (m_pos == 0) begin
      if (n != 0) begin
        m_mcap = md; m_m = cm; m_s = cs;
        if (md != 0 && ch >= 13) begin m_h = ch - 12; m_pm = 1; end
        else begin m_h = ch; m_pm = 0; end
        m_pos = 1;
      end
    end else if (m_pos == 5) begin
      m_pos = 0;
    end else if (k != 0 || md != m_mcap) begin
      m_pos = 0;
    end else if (n != 0) begin
      if (m_pos == 1 && (m_h == 0 || m_h == 12)) m_pm = 0;
      if (m_pos == 3) m_pos = (m_mcap != 0) ? 4 : 5;
      else if (m_pos == 4) m_pos = 5;
      else m_pos = m_pos + 1;
      if (m_pos == 5) begin m_lh = conv(m_h, m_pm); m_lm = m_m; m_ls = m_s; end
    end else if (u != d) begin
      case (m_pos)
        1: m_h = wrap(m_h, u, (m_mcap != 0) ? 12 : 23);
        2: m_m = wrap(m_m, u, 59);
        3: m_s = wrap(m_s, u, 59);
        default: m_pm = (m_h == 0 || m_h == 12) ? 0 : 1 - m_pm;
      endcase
    end
  endtask

  vec_t tbl[29];

  initial begin
    logic [19:0] a, b, c, l1, l2;
    int lc0;
    logic md;

    reset = 1'b1; mod12_24 = 1'b0; cur_time = '0;
    btn_next = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_cancel = 1'b0;

    a = mk(13, 45, 30); b = mk(23, 59, 59); c = mk(7, 15, 0);
    l1 = mk(15, 45, 30); l2 = mk(12, 59, 59);
    // 24h edit of 13:45:30 -> 15:45:30
    tbl[0]  = mkv(1, 0, a, 4'b0000, 0, 0, 0, 20'd0, 0, 20'd0);
    tbl[1]  = mkv(0, 0, a, 4'b1000, 1, 1, 0, a, 0, 20'd0);
    tbl[2]  = mkv(0, 0, a, 4'b0100, 1, 1, 0, mk(14, 45, 30), 0, 20'd0);
    tbl[3]  = mkv(0, 0, a, 4'b0100, 1, 1, 0, l1, 0, 20'd0);
    tbl[4]  = mkv(0, 0, a, 4'b1000, 2, 1, 0, l1, 0, 20'd0);
    tbl[5]  = mkv(0, 0, a, 4'b1000, 3, 1, 0, l1, 0, 20'd0);
    tbl[6]  = mkv(0, 0, a, 4'b1000, 0, 1, 1, l1, 0, l1);
    tbl[7]  = mkv(0, 0, a, 4'b0000, 0, 0, 0, l1, 0, l1);
    // 12h: 23:59:59 -> 11 PM, up to 12, pm cleared leaving HOUR
    tbl[8]  = mkv(0, 1, b, 4'b1000, 1, 1, 0, b, 1, l1);
    tbl[9]  = mkv(0, 1, b, 4'b0100, 1, 1, 0, l2, 1, l1);
    tbl[10] = mkv(0, 1, b, 4'b1000, 2, 1, 0, l2, 0, l1);
    tbl[11] = mkv(0, 1, b, 4'b1000, 3, 1, 0, l2, 0, l1);
    tbl[12] = mkv(0, 1, b, 4'b1000, 3, 1, 0, l2, 0, l1);
    tbl[13] = mkv(0, 1, b, 4'b1000, 0, 1, 1, l2, 0, l2);
    tbl[14] = mkv(0, 1, b, 4'b0000, 0, 0, 0, l2, 0, l2);
    // 12h: 07 AM toggled to PM -> 19
    tbl[15] = mkv(0, 1, c, 4'b1000, 1, 1, 0, c, 0, l2);
    tbl[16] = mkv(0, 1, c, 4'b1000, 2, 1, 0, c, 0, l2);
    tbl[17] = mkv(0, 1, c, 4'b1000, 3, 1, 0, c, 0, l2);
    tbl[18] = mkv(0, 1, c, 4'b1000, 3, 1, 0, c, 0, l2);
    tbl[19] = mkv(0, 1, c, 4'b0100, 3, 1, 0, mk(19, 15, 0), 1, l2);
    tbl[20] = mkv(0, 1, c, 4'b1000, 0, 1, 1, mk(19, 15, 0), 1, mk(19, 15, 0));
    tbl[21] = mkv(0, 1, c, 4'b0000, 0, 0, 0, mk(19, 15, 0), 1, mk(19, 15, 0));
    // up+down ignored, next beats up, reset during COMMIT
    tbl[22] = mkv(0, 1, c, 4'b1000, 1, 1, 0, c, 0, mk(19, 15, 0));
    tbl[23] = mkv(0, 1, c, 4'b0110, 1, 1, 0, c, 0, mk(19, 15, 0));
    tbl[24] = mkv(0, 1, c, 4'b1100, 2, 1, 0, c, 0, mk(19, 15, 0));
    tbl[25] = mkv(0, 1, c, 4'b1000, 3, 1, 0, c, 0, mk(19, 15, 0));
    tbl[26] = mkv(0, 1, c, 4'b1000, 3, 1, 0, c, 0, mk(19, 15, 0));
    tbl[27] = mkv(0, 1, c, 4'b1000, 0, 1, 1, c, 0, c);
    tbl[28] = mkv(1, 1, c, 4'b1000, 0, 0, 0, 20'd0, 0, 20'd0);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].rst, tbl[i].mod, tbl[i].cur, tbl[i].nxt, tbl[i].up, tbl[i].dn, tbl[i].cn);
      chk_all($sformatf("vec%0d", i), tbl[i].f, tbl[i].ed, tbl[i].ld, tbl[i].t, tbl[i].pm, tbl[i].lt);
    end

    // Wraps with no carry, then cancel in MIN
    lc0 = load_cnt;
    drive(0, 0, mk(0, 59, 0), 1, 0, 0, 0);
    drive(0, 0, mk(0, 59, 0), 0, 0, 1, 0);
    chk("hour_wrap_down", edit_time, mk(23, 59, 0));
    drive(0, 0, mk(0, 59, 0), 1, 0, 0, 0);
    drive(0, 0, mk(0, 59, 0), 0, 1, 0, 0);
    chk("min_wrap_up", edit_time, mk(23, 0, 0));
    drive(0, 0, mk(0, 59, 0), 0, 0, 0, 1);
    chk("cancel_editing", {19'd0, editing}, 20'd0);
    drive(0, 0, mk(0, 59, 0), 0, 0, 0, 0);
    chk("cancel_load_time", load_time, 20'd0);
    // sec wrap down, then mode toggle in SEC aborts
    drive(0, 0, mk(0, 59, 0), 1, 0, 0, 0);
    drive(0, 0, mk(0, 59, 0), 1, 0, 0, 0);
    drive(0, 0, mk(0, 59, 0), 1, 0, 0, 0);
    drive(0, 0, mk(0, 59, 0), 0, 0, 1, 0);
    chk("sec_wrap_down", edit_time, mk(0, 59, 59));
    drive(0, 1, mk(0, 59, 0), 0, 0, 0, 0);
    chk("mode_abort_editing", {19'd0, editing}, 20'd0);
    // cancel beats next
    drive(0, 1, mk(0, 59, 0), 1, 0, 0, 0);
    drive(0, 1, mk(0, 59, 0), 1, 0, 0, 1);
    chk("cancel_over_next", {19'd0, editing}, 20'd0);
    drive(0, 1, mk(0, 59, 0), 0, 0, 0, 0);
    chk("abort_load_time", load_time, 20'd0);
    chk("abort_no_load", 20'(load_cnt - lc0), 20'd0);

    // Random phase against the model
    md = 1'b0;
    drive(1, md, '0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int ch, cm, cs;
      logic r, n, u, d, k;
      ch = int'($urandom_range(0, 23));
      cm = int'($urandom_range(0, 59));
      cs = int'($urandom_range(0, 59));
      r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) md = ~md;
      n  = ($urandom_range(0, 3) == 0);
      u  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      k  = ($urandom_range(0, 39) == 0);
      drive(r, md, mk(ch, cm, cs), n, u, d, k);
      model_step(int'(r), int'(md), ch, cm, cs, int'(n), int'(u), int'(d), int'(k));
      chk_all($sformatf("rnd%0d", i),
              (m_pos == 1) ? 2'd1 : (m_pos == 2) ? 2'd2 : (m_pos == 3 || m_pos == 4) ? 2'd3 : 2'd0,
              m_pos != 0, m_pos == 5, mk(conv(m_h, m_pm), m_m, m_s), m_pm != 0,
              mk(m_lh, m_lm, m_ls));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
